time_keeper: RTL and testbench

- Running timekeeper at the receiving end of the time-edit interface.
- Accepts the six edited BCD digits plus the edit-mode flag from the time editor.
- Produces the live HH:MM:SS digits that feed back into the editor and onward to the display.
- Counts seconds from an internal prescaler. Holds and loads while edit is active, sanitises illegal values when edit is released, and wraps 23:59:59 to 00:00:00.

---
 rtl/time_pkg.sv | 19 +
 rtl/tick_gen.sv | 29 ++
 rtl/time_keeper.sv | 121 ++++++++++++
 tb/tb_time_keeper.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared time-of-day digit type and per-digit limits, also used by the editor and display driver.
package time_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC0_MAX       = 4'd9;
  localparam bcd_t SEC1_MAX       = 4'd5;
  localparam bcd_t MIN0_MAX       = 4'd9;
  localparam bcd_t MIN1_MAX       = 4'd5;
  localparam bcd_t HRS0_MAX       = 4'd9;
  localparam bcd_t HRS1_MAX       = 4'd2;
  localparam bcd_t HRS0_MAX_AT_20 = 4'd3;

  // Out-of-range digits collapse to zero rather than saturating.
  function automatic bcd_t clip(input bcd_t d, input bcd_t lim);
    return (d > lim) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Divide-by-DIV prescaler; strobe is high in the last cycle of each period, clr holds it at zero.
module tick_gen #(
  parameter int unsigned DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic strobe
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign strobe = !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (clr || strobe) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/time_keeper.sv
// Live HH:MM:SS counter: loads while edit is held, cleans up illegal digits on release,
// then counts one second per prescaler strobe and wraps at midnight.
module time_keeper
  import time_pkg::*;
#(
  parameter int unsigned DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edit,
  input  logic [3:0] ld_sec0,
  input  logic [3:0] ld_sec1,
  input  logic [3:0] ld_min0,
  input  logic [3:0] ld_min1,
  input  logic [3:0] ld_hrs0,
  input  logic [3:0] ld_hrs1,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic [3:0] hrs0,
  output logic [3:0] hrs1,
  output logic       tick,
  output logic       day_wrap
);

  logic strobe;
  logic edit_d;
  bcd_t sec0_next, sec1_next, min0_next, min1_next, hrs0_next, hrs1_next;
  logic tick_next, wrap_next;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (edit),
    .strobe (strobe)
  );

  always_comb begin
    sec0_next = sec0;
    sec1_next = sec1;
    min0_next = min0;
    min1_next = min1;
    hrs0_next = hrs0;
    hrs1_next = hrs1;
    tick_next = 1'b0;
    wrap_next = 1'b0;
    if (edit) begin
      sec0_next = ld_sec0;
      sec1_next = ld_sec1;
      min0_next = ld_min0;
      min1_next = ld_min1;
      hrs0_next = ld_hrs0;
      hrs1_next = ld_hrs1;
    end else if (edit_d) begin
      // Prescaler was just cleared, so no strobe can collide with this pass.
      sec0_next = clip(sec0, SEC0_MAX);
      sec1_next = clip(sec1, SEC1_MAX);
      min0_next = clip(min0, MIN0_MAX);
      min1_next = clip(min1, MIN1_MAX);
      hrs0_next = clip(hrs0, HRS0_MAX);
      hrs1_next = clip(hrs1, HRS1_MAX);
      if (hrs1_next == HRS1_MAX && hrs0_next > HRS0_MAX_AT_20) hrs0_next = HRS0_MAX_AT_20;
    end else if (strobe) begin
      tick_next = 1'b1;
      if (sec0 != SEC0_MAX) sec0_next = sec0 + 4'd1;
      else begin
        sec0_next = 4'd0;
        if (sec1 != SEC1_MAX) sec1_next = sec1 + 4'd1;
        else begin
          sec1_next = 4'd0;
          if (min0 != MIN0_MAX) min0_next = min0 + 4'd1;
          else begin
            min0_next = 4'd0;
            if (min1 != MIN1_MAX) min1_next = min1 + 4'd1;
            else begin
              min1_next = 4'd0;
              if (hrs1 == HRS1_MAX && hrs0 == HRS0_MAX_AT_20) begin
                hrs0_next = 4'd0;
                hrs1_next = 4'd0;
                wrap_next = 1'b1;
              end else if (hrs0 == HRS0_MAX) begin
                hrs0_next = 4'd0;
                hrs1_next = hrs1 + 4'd1;
              end else begin
                hrs0_next = hrs0 + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec0     <= 4'd0;
      sec1     <= 4'd0;
      min0     <= 4'd0;
      min1     <= 4'd0;
      hrs0     <= 4'd0;
      hrs1     <= 4'd0;
      tick     <= 1'b0;
      day_wrap <= 1'b0;
      edit_d   <= 1'b0;
    end else begin
      sec0     <= sec0_next;
      sec1     <= sec1_next;
      min0     <= min0_next;
      min1     <= min1_next;
      hrs0     <= hrs0_next;
      hrs1     <= hrs1_next;
      tick     <= tick_next;
      day_wrap <= wrap_next;
      edit_d   <= edit;
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed scenarios plus random edit/run traffic
// against a seconds-of-day reference model.
module tb_time_keeper;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       edit = 1'b0;
  logic [3:0] ld_sec0 = '0, ld_sec1 = '0, ld_min0 = '0, ld_min1 = '0, ld_hrs0 = '0, ld_hrs1 = '0;
  logic [3:0] sec0, sec1, min0, min1, hrs0, hrs1;
  logic       tick, day_wrap;

  time_keeper #(
    .DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .edit     (edit),
    .ld_sec0  (ld_sec0),
    .ld_sec1  (ld_sec1),
    .ld_min0  (ld_min0),
    .ld_min1  (ld_min1),
    .ld_hrs0  (ld_hrs0),
    .ld_hrs1  (ld_hrs1),
    .sec0     (sec0),
    .sec1     (sec1),
    .min0     (min0),
    .min1     (min1),
    .hrs0     (hrs0),
    .hrs1     (hrs1),
    .tick     (tick),
    .day_wrap (day_wrap)
  );

  always #5 clk = ~clk;

  // Observed state as {HHMMSS digits, tick, day_wrap}.
  logic [25:0] dut_vec;
  assign dut_vec = {hrs1, hrs0, min1, min0, sec1, sec0, tick, day_wrap};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: digits held as plain integers (index 0 = sec0 .. 5 = hrs1),
  // counting done on seconds-of-day.
  int m_d[6];
  int m_phase = 0;
  bit m_prev  = 1'b0;
  bit m_tick  = 1'b0;
  bit m_wrap  = 1'b0;
  int lim[6]  = '{9, 5, 9, 5, 9, 2};

  function automatic void model_clear();
    for (int i = 0; i < 6; i++) m_d[i] = 0;
    m_phase = 0;
    m_prev  = 1'b0;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
  endfunction

  function automatic void model_edge();
    int t;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (!rst) begin
      model_clear();
      return;
    end
    if (edit) begin
      m_d[0] = int'(ld_sec0); m_d[1] = int'(ld_sec1); m_d[2] = int'(ld_min0);
      m_d[3] = int'(ld_min1); m_d[4] = int'(ld_hrs0); m_d[5] = int'(ld_hrs1);
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_prev) begin
        for (int i = 0; i < 6; i++) if (m_d[i] > lim[i]) m_d[i] = 0;
        if (m_d[5] == 2 && m_d[4] > 3) m_d[4] = 3;
      end else if (m_phase == DIV) begin
        m_phase = 0;
        t = (m_d[5] * 10 + m_d[4]) * 3600 + (m_d[3] * 10 + m_d[2]) * 60 + m_d[1] * 10 + m_d[0];
        m_wrap = (t == 86399);
        t = (t + 1) % 86400;
        m_d[5] = t / 36000;        m_d[4] = (t / 3600) % 10;
        m_d[3] = (t % 3600) / 600; m_d[2] = (t / 60) % 10;
        m_d[1] = (t % 60) / 10;    m_d[0] = t % 10;
        m_tick = 1'b1;
      end
    end
    m_prev = edit;
  endfunction

  function automatic logic [25:0] model_vec();
    return {m_d[5][3:0], m_d[4][3:0], m_d[3][3:0], m_d[2][3:0], m_d[1][3:0], m_d[0][3:0],
            m_tick, m_wrap};
  endfunction

  task automatic step(input logic e);
    edit = e;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_ld(input logic [23:0] hhmmss);
    {ld_hrs1, ld_hrs0, ld_min1, ld_min0, ld_sec1, ld_sec0} = hhmmss;
  endtask

  task automatic load(input logic [23:0] hhmmss);
    set_ld(hhmmss);
    step(1'b1);
    step(1'b0);
  endtask

  task automatic test_reset();
    logic [25:0] exp;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) step(1'b0);
    n_tests++;
    if (dut_vec !== 26'h0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, 26'h0);
    end
    rst = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      exp = model_vec();
      if (i < 4) exp = 26'h0;
      if (i == 4) exp = {24'h000001, 2'b10};
      if (i == 40) exp = {24'h000010, 2'b10};
      n_tests++;
      if (dut_vec !== exp) begin
        n_fail++; $display("FAIL reset_count cyc %0d: got %h expected %h", i, dut_vec, exp);
      end
    end
  endtask

  task automatic run_to_tick(input logic [25:0] exp, input string name);
    for (int i = 0; i < 2 * DIV; i++) begin
      step(1'b0);
      if (m_tick) break;
    end
    n_tests++;
    if (dut_vec !== exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", name, dut_vec, exp);
    end
  endtask

  task automatic test_minute_carry();
    load(24'h000059);
    run_to_tick({24'h000100, 2'b10}, "minute_carry");
    load(24'h095959);
    run_to_tick({24'h100000, 2'b10}, "hour_tens_carry");
  endtask

  task automatic test_day_wrap();
    load(24'h235959);
    run_to_tick({24'h000000, 2'b11}, "day_wrap");
    step(1'b0);
    n_tests++;
    if (dut_vec !== 26'h0) begin
      n_fail++; $display("FAIL day_wrap_one_cycle: got %h expected %h", dut_vec, 26'h0);
    end
  endtask

  task automatic test_sanitise();
    load(24'h277398);
    n_tests++;
    if (dut_vec !== {24'h230308, 2'b00}) begin
      n_fail++; $display("FAIL sanitise: got %h expected %h", dut_vec, {24'h230308, 2'b00});
    end
  endtask

  task automatic test_edit_collision();
    for (int i = 0; i < 2 * DIV && m_phase != DIV - 1; i++) step(1'b0);
    set_ld(24'h123456);
    for (int i = 0; i < 11; i++) begin
      step(1'b1);
      n_tests++;
      if (dut_vec !== {24'h123456, 2'b00}) begin
        n_fail++; $display("FAIL collision_hold %0d: got %h expected %h", i, dut_vec,
                           {24'h123456, 2'b00});
      end
    end
    for (int i = 1; i <= DIV; i++) begin
      step(1'b0);
      n_tests++;
      if (dut_vec !== ((i == DIV) ? {24'h123457, 2'b10} : {24'h123456, 2'b00})) begin
        n_fail++; $display("FAIL collision_release cyc %0d: got %h", i, dut_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    load(24'h050607);
    n_tests++;
    if (dut_vec !== {24'h050607, 2'b00}) begin
      n_fail++; $display("FAIL async_preload: got %h expected %h", dut_vec, {24'h050607, 2'b00});
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (dut_vec !== 26'h0) begin
      n_fail++; $display("FAIL async_reset_immediate: got %h expected %h", dut_vec, 26'h0);
    end
    step(1'b0);
    rst = 1'b1;
    for (int i = 1; i <= DIV; i++) begin
      step(1'b0);
      n_tests++;
      if (dut_vec !== ((i == DIV) ? {24'h000001, 2'b10} : 26'h0)) begin
        n_fail++; $display("FAIL async_reset_recover cyc %0d: got %h", i, dut_vec);
      end
    end
  endtask

  task automatic test_random();
    logic [25:0] exp;
    int          nrun;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        {ld_hrs1, ld_hrs0, ld_min1, ld_min0, ld_sec1} = {4'd2, 4'd3, 4'd5, 4'd9, 4'd5};
        ld_sec0 = 4'($urandom_range(5, 9));
      end else begin
        set_ld(24'($urandom));
      end
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        step(1'b1);
        exp = model_vec();
        n_tests++;
        if (dut_vec !== exp) begin
          n_fail++; $display("FAIL random_edit %0d: got %h expected %h", k, dut_vec, exp);
        end
      end
      nrun = int'($urandom_range(1, 30));
      for (int i = 0; i < nrun; i++) begin
        step(1'b0);
        exp = model_vec();
        n_tests++;
        if (dut_vec !== exp) begin
          n_fail++; $display("FAIL random_run %0d/%0d: got %h expected %h", k, i, dut_vec, exp);
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    model_clear();
    test_reset();
    test_minute_carry();
    test_day_wrap();
    test_sanitise();
    test_edit_collision();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
